dp_sequencer: RTL

DP_SEQUENCER -- requirements
Module: dp_sequencer

---
 rtl/dp_sequencer_pkg.sv | 27 ++
 rtl/dp_sequencer_if.sv | 17 +
 rtl/cmd_fifo.sv | 53 +++++
 rtl/dp_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dp_sequencer_pkg.sv
// Shared constants for the datapath sequencer: opcodes, field widths and the queued command layout.
package dp_sequencer_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned CMD_W = 3 * REG_W + OP_W;

    localparam logic [OP_W-1:0] OP_ADD = 7'h01;
    localparam logic [OP_W-1:0] OP_SUB = 7'h02;
    localparam logic [OP_W-1:0] OP_AND = 7'h03;
    localparam logic [OP_W-1:0] OP_OR  = 7'h04;
    localparam logic [OP_W-1:0] OP_DIV = 7'h05;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rw;
        logic [OP_W-1:0]  op;
    } cmd_t;

    // True for opcodes the datapath implements; anything else retires as an error.
    function automatic logic op_known(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Command handshake between a requester (master) and the sequencer (slave).
interface dp_sequencer_if;
    import dp_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [REG_W-1:0] cmd_rs1;
    logic [REG_W-1:0] cmd_rs2;
    logic [REG_W-1:0] cmd_rw;
    logic [OP_W-1:0]  cmd_op;

    modport master (output cmd_valid, output cmd_rs1, output cmd_rs2, output cmd_rw,
                    output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs1, input cmd_rs2, input cmd_rw,
                    input cmd_op, output cmd_ready);

endinterface

// File: rtl/cmd_fifo.sv
// Command queue: power-of-two depth ring buffer with occupancy count; pointers wrap naturally.
module cmd_fifo #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dp_sequencer.sv
// Queues datapath commands and issues them in order, holding DIV operands for a fixed latency.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    dp_sequencer_if.slave    cmd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rw,
    output logic [OP_W-1:0]  operation,
    output logic             write,
    input  logic             zero_flag,
    output logic             done,
    output logic             done_zero,
    output logic             err,
    output logic             busy
);

    localparam int unsigned DCNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_DIV_WAIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [DCNT_W-1:0]   div_cnt;
    cmd_t                push_cmd;
    cmd_t                head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                wb;
    logic                load_cnt;
    logic                is_div;

    assign push_cmd = '{rs1: cmd.cmd_rs1, rs2: cmd.cmd_rs2, rw: cmd.cmd_rw, op: cmd.cmd_op};

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd.cmd_valid),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;
    assign busy          = (state != S_IDLE) || !fifo_empty;
    assign is_div        = (operation == OP_DIV);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_div)          state_nx = S_DIV_WAIT;
                else if (fifo_empty) state_nx = S_IDLE;
            end
            S_DIV_WAIT: begin
                if (div_cnt == '0) state_nx = fifo_empty ? S_IDLE : S_ISSUE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode: writeback cycle, queue pop and divider counter load
    always_comb begin
        wb       = 1'b0;
        pop      = 1'b0;
        load_cnt = 1'b0;
        unique case (state)
            S_IDLE: begin
                pop = !fifo_empty;
            end
            S_ISSUE: begin
                if (is_div) begin
                    load_cnt = 1'b1;
                end else begin
                    wb  = 1'b1;
                    pop = !fifo_empty;
                end
            end
            S_DIV_WAIT: begin
                if (div_cnt == '0) begin
                    wb  = 1'b1;
                    pop = !fifo_empty;
                end
            end
            default: ;
        endcase
    end

    // x0 is hardwired and unknown opcodes never touch the register file.
    assign write = wb && op_known(operation) && (rw != '0);

    // Operand registers, divider countdown and retire pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1       <= '0;
            rs2       <= '0;
            rw        <= '0;
            operation <= '0;
            div_cnt   <= '0;
            done      <= 1'b0;
            done_zero <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (pop) begin
                rs1       <= head.rs1;
                rs2       <= head.rs2;
                rw        <= head.rw;
                operation <= head.op;
            end
            if (load_cnt)
                div_cnt <= DCNT_W'(DIV_LATENCY - 1);
            else if ((state == S_DIV_WAIT) && (div_cnt != '0))
                div_cnt <= div_cnt - DCNT_W'(1);
            done      <= wb;
            done_zero <= wb && zero_flag;
            err       <= wb && !op_known(operation);
        end
    end

endmodule
